// File: rtl/turf_udp_pkg.sv
// Shared types and helpers for the TURF UDP framer.
// The optional length checker is built only with TURF_UDP_FRAMER_LENCHECK_EN defined.
package turf_udp_pkg;

   localparam int          UDP_HDR_BYTES         = 8;
   localparam logic [15:0] FRAMER_DEFAULT_DPORT  = 16'h5555;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE    = 2'd0;
   localparam state_t ST_HEADER  = 2'd1;
   localparam state_t ST_PAYLOAD = 2'd2;

   // Network byte order: byte 0 (src MSB) lands on tdata[7:0]; checksum is always zero.
   function automatic logic [63:0] udp_hdr_word(input logic [15:0] src,
                                                input logic [15:0] dst,
                                                input logic [15:0] len);
      return {8'h00, 8'h00, len[7:0], len[15:8], dst[7:0], dst[15:8], src[7:0], src[15:8]};
   endfunction

endpackage

// File: rtl/turf_udp_framer_if.sv
// Stream bundle around the framer: header in, payload in, framed UDP out.
// slave = framer view, master = the surrounding upstream/downstream view.
interface turf_udp_framer_if;

   logic [15:0] s_hdr_tdata;
   logic [15:0] s_hdr_tuser;
   logic        s_hdr_tvalid;
   logic        s_hdr_tready;

   logic [63:0] s_payload_tdata;
   logic [7:0]  s_payload_tkeep;
   logic        s_payload_tlast;
   logic        s_payload_tuser;
   logic        s_payload_tvalid;
   logic        s_payload_tready;

   logic [63:0] m_udp_tdata;
   logic [7:0]  m_udp_tkeep;
   logic        m_udp_tlast;
   logic        m_udp_tuser;
   logic        m_udp_tvalid;
   logic        m_udp_tready;

   modport slave (
      input  s_hdr_tdata, s_hdr_tuser, s_hdr_tvalid,
      output s_hdr_tready,
      input  s_payload_tdata, s_payload_tkeep, s_payload_tlast, s_payload_tuser, s_payload_tvalid,
      output s_payload_tready,
      output m_udp_tdata, m_udp_tkeep, m_udp_tlast, m_udp_tuser, m_udp_tvalid,
      input  m_udp_tready
   );

   modport master (
      output s_hdr_tdata, s_hdr_tuser, s_hdr_tvalid,
      input  s_hdr_tready,
      output s_payload_tdata, s_payload_tkeep, s_payload_tlast, s_payload_tuser, s_payload_tvalid,
      input  s_payload_tready,
      input  m_udp_tdata, m_udp_tkeep, m_udp_tlast, m_udp_tuser, m_udp_tvalid,
      output m_udp_tready
   );

endinterface

// File: rtl/turf_udp_lencheck.sv
// Payload byte counter checked against the header length at tlast.
// Used only when TURF_UDP_FRAMER_LENCHECK_EN is defined.
module turf_udp_lencheck
   import turf_udp_pkg::*;
(
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        beat_fire,
   input  logic [7:0]  beat_keep,
   input  logic        beat_last,
   input  logic [15:0] exp_len,
   output logic        len_err_o,
   output logic [15:0] len_err_count_o
);

   logic [15:0] byte_cnt_q;
   logic        part_err_q;
   logic [3:0]  keep_bytes;
   logic [15:0] byte_total;
   logic        beat_part_err;
   logic        frame_err;

   always_comb begin
      keep_bytes = 4'd0;
      for (int i = 0; i < 8; i++) keep_bytes = keep_bytes + {3'b000, beat_keep[i]};
   end

   assign byte_total    = byte_cnt_q + {12'h000, keep_bytes};
   // Only the closing beat may be partially filled.
   assign beat_part_err = !beat_last && (beat_keep != 8'hFF);
   assign frame_err     = (byte_total != exp_len) || part_err_q;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         byte_cnt_q      <= 16'h0000;
         part_err_q      <= 1'b0;
         len_err_o       <= 1'b0;
         len_err_count_o <= 16'h0000;
      end else begin
         len_err_o <= 1'b0;
         if (beat_fire) begin
            if (beat_last) begin
               byte_cnt_q <= 16'h0000;
               part_err_q <= 1'b0;
               if (frame_err) begin
                  len_err_o <= 1'b1;
                  if (len_err_count_o != 16'hFFFF) len_err_count_o <= len_err_count_o + 16'h0001;
               end
            end else begin
               byte_cnt_q <= byte_total;
               part_err_q <= part_err_q | beat_part_err;
            end
         end
      end
   end

endmodule

// File: rtl/turf_udp_framer.sv
// Prepends an 8-byte UDP header beat to each 64-bit payload fragment.
// Define TURF_UDP_FRAMER_LENCHECK_EN to add the payload length checker and its ports.
module turf_udp_framer
   import turf_udp_pkg::*;
(
   input  logic        aclk,
   input  logic        aresetn,
   input  logic [15:0] dest_port_i,
   turf_udp_framer_if.slave bus
`ifdef TURF_UDP_FRAMER_LENCHECK_EN
   ,
   output logic        len_err_o,
   output logic [15:0] len_err_count_o
`endif
);

   state_t      state_q, state_d;
   logic [15:0] src_port_q;
   logic [15:0] dst_port_q;
   logic [15:0] udp_len_q;
   logic        pl_fire;

   assign pl_fire = (state_q == ST_PAYLOAD) && bus.s_payload_tvalid && bus.m_udp_tready;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (bus.s_hdr_tvalid) state_d = ST_HEADER;
         ST_HEADER:  if (bus.m_udp_tready) state_d = ST_PAYLOAD;
         ST_PAYLOAD: if (pl_fire && bus.s_payload_tlast) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // Header fields are captured once so the header beat holds steady under backpressure.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         src_port_q <= 16'h0000;
         dst_port_q <= 16'h0000;
         udp_len_q  <= 16'h0000;
      end else if (state_q == ST_IDLE && bus.s_hdr_tvalid) begin
         src_port_q <= bus.s_hdr_tuser;
         dst_port_q <= (dest_port_i == 16'h0000) ? FRAMER_DEFAULT_DPORT : dest_port_i;
         udp_len_q  <= bus.s_hdr_tdata + 16'(UDP_HDR_BYTES);
      end
   end

   always_comb begin
      bus.s_hdr_tready     = 1'b0;
      bus.s_payload_tready = 1'b0;
      bus.m_udp_tvalid     = 1'b0;
      bus.m_udp_tdata      = 64'h0;
      bus.m_udp_tkeep      = 8'h00;
      bus.m_udp_tlast      = 1'b0;
      bus.m_udp_tuser      = 1'b0;
      case (state_q)
         ST_IDLE: bus.s_hdr_tready = 1'b1;
         ST_HEADER: begin
            bus.m_udp_tvalid = 1'b1;
            bus.m_udp_tdata  = udp_hdr_word(src_port_q, dst_port_q, udp_len_q);
            bus.m_udp_tkeep  = 8'hFF;
         end
         ST_PAYLOAD: begin
            bus.m_udp_tvalid     = bus.s_payload_tvalid;
            bus.s_payload_tready = bus.m_udp_tready;
            bus.m_udp_tdata      = bus.s_payload_tdata;
            bus.m_udp_tkeep      = bus.s_payload_tkeep;
            bus.m_udp_tlast      = bus.s_payload_tlast;
            bus.m_udp_tuser      = bus.s_payload_tuser;
         end
         default: ;
      endcase
   end

`ifdef TURF_UDP_FRAMER_LENCHECK_EN
   // Registered udp_len includes the header; the payload should carry exactly the original length.
   turf_udp_lencheck u_lencheck (
      .aclk            (aclk),
      .aresetn         (aresetn),
      .beat_fire       (pl_fire),
      .beat_keep       (bus.s_payload_tkeep),
      .beat_last       (bus.s_payload_tlast),
      .exp_len         (udp_len_q - 16'(UDP_HDR_BYTES)),
      .len_err_o       (len_err_o),
      .len_err_count_o (len_err_count_o)
   );
`endif

endmodule

// File: tb/tb_turf_udp_framer.sv
// Directed table-driven bench for turf_udp_framer, plus reset and length-check sequences.
module tb_turf_udp_framer;

   logic        aclk;
   logic        aresetn;
   logic [15:0] dport;
   int          errors = 0;
   int          checks = 0;

   turf_udp_framer_if bus();

`ifdef TURF_UDP_FRAMER_LENCHECK_EN
   logic        len_err;
   logic [15:0] len_err_count;
`endif

   turf_udp_framer dut (
      .aclk            (aclk),
      .aresetn         (aresetn),
      .dest_port_i     (dport),
      .bus             (bus)
`ifdef TURF_UDP_FRAMER_LENCHECK_EN
      ,
      .len_err_o       (len_err),
      .len_err_count_o (len_err_count)
`endif
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   localparam logic [63:0] Z64 = 64'h0;
   localparam logic [63:0] P0 = 64'h0123_4567_89AB_CDEF;
   localparam logic [63:0] P1 = 64'hFEDC_BA98_7654_3210;
   localparam logic [63:0] P2 = 64'hDEAD_BEEF_CAFE_F00D;
   localparam logic [63:0] P3 = 64'h1111_2222_3333_4444;
   localparam logic [63:0] P4 = 64'hA5A5_5A5A_0F0F_F0F0;
   localparam logic [63:0] P5 = 64'h0000_0000_FFFF_FFFF;
   localparam logic [63:0] P6 = 64'h8877_6655_4433_2211;
   localparam logic [63:0] P7 = 64'h1020_3040_5060_7080;

   typedef struct {
      logic        hv; logic [15:0] hd; logic [15:0] hu; logic [15:0] dp;
      logic        pv; logic [63:0] pd; logic [7:0] pk; logic pl; logic pu;
      logic        mr;
      logic        ev; logic [63:0] ed; logic [7:0] ek; logic el; logic eu;
      logic        ehr; logic epr;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(input logic hv, input logic [15:0] hd, input logic [15:0] hu,
                               input logic [15:0] dp, input logic pv, input logic [63:0] pd,
                               input logic [7:0] pk, input logic pl, input logic pu, input logic mr,
                               input logic ev, input logic [63:0] ed, input logic [7:0] ek,
                               input logic el, input logic eu, input logic ehr, input logic epr);
      vec_t v;
      v.hv = hv; v.hd = hd; v.hu = hu; v.dp = dp;
      v.pv = pv; v.pd = pd; v.pk = pk; v.pl = pl; v.pu = pu; v.mr = mr;
      v.ev = ev; v.ed = ed; v.ek = ek; v.el = el; v.eu = eu; v.ehr = ehr; v.epr = epr;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // One vector = one clock: drive after the edge, compare at the falling edge.
   task automatic apply(input vec_t v, input string tag);
      bus.s_hdr_tvalid     = v.hv; bus.s_hdr_tdata = v.hd; bus.s_hdr_tuser = v.hu; dport = v.dp;
      bus.s_payload_tvalid = v.pv; bus.s_payload_tdata = v.pd; bus.s_payload_tkeep = v.pk;
      bus.s_payload_tlast  = v.pl; bus.s_payload_tuser = v.pu; bus.m_udp_tready = v.mr;
      @(negedge aclk);
      chk({tag, " m_tvalid"}, 64'(bus.m_udp_tvalid), 64'(v.ev));
      chk({tag, " hdr_tready"}, 64'(bus.s_hdr_tready), 64'(v.ehr));
      chk({tag, " pl_tready"}, 64'(bus.s_payload_tready), 64'(v.epr));
      if (v.ev) begin
         chk({tag, " m_tdata"}, bus.m_udp_tdata, v.ed);
         chk({tag, " m_tkeep"}, 64'(bus.m_udp_tkeep), 64'(v.ek));
         chk({tag, " m_tlast"}, 64'(bus.m_udp_tlast), 64'(v.el));
         chk({tag, " m_tuser"}, 64'(bus.m_udp_tuser), 64'(v.eu));
      end
      @(posedge aclk); #1;
   endtask

   task automatic idle_inputs();
      bus.s_hdr_tvalid = 1'b0; bus.s_hdr_tdata = 16'h0; bus.s_hdr_tuser = 16'h0;
      bus.s_payload_tvalid = 1'b0; bus.s_payload_tdata = Z64; bus.s_payload_tkeep = 8'h00;
      bus.s_payload_tlast = 1'b0; bus.s_payload_tuser = 1'b0; bus.m_udp_tready = 1'b0;
   endtask

   initial begin
      // Length and framing: len 24 -> 32, src 5430, dst 4567
      vq.push_back(mk(1'b1,16'd24,16'h5430,16'h4567, 1'b1,P0,8'hFF,1'b0,1'b0, 1'b1, 1'b0,Z64,8'h00,1'b0,1'b0, 1'b1,1'b0));
      vq.push_back(mk(1'b0,16'h0,16'h0,16'h4567, 1'b1,P0,8'hFF,1'b0,1'b0, 1'b1, 1'b1,64'h0000_2000_6745_3054,8'hFF,1'b0,1'b0, 1'b0,1'b0));
      vq.push_back(mk(1'b0,16'h0,16'h0,16'h4567, 1'b1,P0,8'hFF,1'b0,1'b0, 1'b1, 1'b1,P0,8'hFF,1'b0,1'b0, 1'b0,1'b1));
      vq.push_back(mk(1'b0,16'h0,16'h0,16'h4567, 1'b1,P1,8'hFF,1'b0,1'b1, 1'b1, 1'b1,P1,8'hFF,1'b0,1'b1, 1'b0,1'b1));
      vq.push_back(mk(1'b0,16'h0,16'h0,16'h4567, 1'b1,P2,8'hFF,1'b1,1'b0, 1'b1, 1'b1,P2,8'hFF,1'b1,1'b0, 1'b0,1'b1));
      vq.push_back(mk(1'b0,16'h0,16'h0,16'h4567, 1'b0,Z64,8'h00,1'b0,1'b0, 1'b1, 1'b0,Z64,8'h00,1'b0,1'b0, 1'b1,1'b0));
      // Default destination port: src 1234, len 8 -> 16
      vq.push_back(mk(1'b1,16'd8,16'h1234,16'h0000, 1'b0,Z64,8'h00,1'b0,1'b0, 1'b1, 1'b0,Z64,8'h00,1'b0,1'b0, 1'b1,1'b0));
      vq.push_back(mk(1'b0,16'h0,16'h0,16'h0000, 1'b0,Z64,8'h00,1'b0,1'b0, 1'b1, 1'b1,64'h0000_1000_5555_3412,8'hFF,1'b0,1'b0, 1'b0,1'b0));
      vq.push_back(mk(1'b0,16'h0,16'h0,16'h0000, 1'b0,Z64,8'h00,1'b0,1'b0, 1'b1, 1'b0,Z64,8'h00,1'b0,1'b0, 1'b0,1'b1));
      vq.push_back(mk(1'b0,16'h0,16'h0,16'h0000, 1'b1,P3,8'hFF,1'b1,1'b0, 1'b1, 1'b1,P3,8'hFF,1'b1,1'b0, 1'b0,1'b1));
      // Backpressure 0/1 through header and payload: src ABCD, dst 0102, len 16 -> 24
      vq.push_back(mk(1'b1,16'd16,16'hABCD,16'h0102, 1'b1,P4,8'hFF,1'b0,1'b0, 1'b1, 1'b0,Z64,8'h00,1'b0,1'b0, 1'b1,1'b0));
      vq.push_back(mk(1'b0,16'h0,16'h0,16'h0102, 1'b1,P4,8'hFF,1'b0,1'b0, 1'b0, 1'b1,64'h0000_1800_0201_CDAB,8'hFF,1'b0,1'b0, 1'b0,1'b0));
      vq.push_back(mk(1'b0,16'h0,16'h0,16'h0102, 1'b1,P4,8'hFF,1'b0,1'b0, 1'b1, 1'b1,64'h0000_1800_0201_CDAB,8'hFF,1'b0,1'b0, 1'b0,1'b0));
      vq.push_back(mk(1'b0,16'h0,16'h0,16'h0102, 1'b1,P4,8'hFF,1'b0,1'b0, 1'b0, 1'b1,P4,8'hFF,1'b0,1'b0, 1'b0,1'b0));
      vq.push_back(mk(1'b0,16'h0,16'h0,16'h0102, 1'b1,P4,8'hFF,1'b0,1'b0, 1'b1, 1'b1,P4,8'hFF,1'b0,1'b0, 1'b0,1'b1));
      vq.push_back(mk(1'b0,16'h0,16'h0,16'h0102, 1'b1,P5,8'hFF,1'b1,1'b0, 1'b0, 1'b1,P5,8'hFF,1'b1,1'b0, 1'b0,1'b0));
      vq.push_back(mk(1'b0,16'h0,16'h0,16'h0102, 1'b1,P5,8'hFF,1'b1,1'b0, 1'b1, 1'b1,P5,8'hFF,1'b1,1'b0, 1'b0,1'b1));
      vq.push_back(mk(1'b0,16'h0,16'h0,16'h0102, 1'b0,Z64,8'h00,1'b0,1'b0, 1'b0, 1'b0,Z64,8'h00,1'b0,1'b0, 1'b1,1'b0));
      vq.push_back(mk(1'b0,16'h0,16'h0,16'h0002, 1'b1,P6,8'h0F,1'b1,1'b0, 1'b1, 1'b0,Z64,8'h00,1'b0,1'b0, 1'b1,1'b0));
      // Back-to-back headers, single 4-byte beats: len 4 -> 12
      vq.push_back(mk(1'b1,16'd4,16'h0001,16'h0002, 1'b1,P6,8'h0F,1'b1,1'b0, 1'b1, 1'b0,Z64,8'h00,1'b0,1'b0, 1'b1,1'b0));
      vq.push_back(mk(1'b1,16'd4,16'h0003,16'h0002, 1'b1,P6,8'h0F,1'b1,1'b0, 1'b1, 1'b1,64'h0000_0C00_0200_0100,8'hFF,1'b0,1'b0, 1'b0,1'b0));
      vq.push_back(mk(1'b1,16'd4,16'h0003,16'h0002, 1'b1,P6,8'h0F,1'b1,1'b0, 1'b1, 1'b1,P6,8'h0F,1'b1,1'b0, 1'b0,1'b1));
      vq.push_back(mk(1'b1,16'd4,16'h0003,16'h0002, 1'b1,P7,8'h0F,1'b1,1'b1, 1'b1, 1'b0,Z64,8'h00,1'b0,1'b0, 1'b1,1'b0));
      vq.push_back(mk(1'b0,16'h0,16'h0,16'h0002, 1'b1,P7,8'h0F,1'b1,1'b1, 1'b1, 1'b1,64'h0000_0C00_0200_0300,8'hFF,1'b0,1'b0, 1'b0,1'b0));
      vq.push_back(mk(1'b0,16'h0,16'h0,16'h0002, 1'b1,P7,8'h0F,1'b1,1'b1, 1'b1, 1'b1,P7,8'h0F,1'b1,1'b1, 1'b0,1'b1));
      vq.push_back(mk(1'b0,16'h0,16'h0,16'h0002, 1'b0,Z64,8'h00,1'b0,1'b0, 1'b1, 1'b0,Z64,8'h00,1'b0,1'b0, 1'b1,1'b0));

      // Reset state
      aresetn = 1'b0; dport = 16'h0; idle_inputs();
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      chk("reset m_tvalid", 64'(bus.m_udp_tvalid), 64'h0);
      chk("reset pl_tready", 64'(bus.s_payload_tready), 64'h0);
      chk("reset hdr_tready", 64'(bus.s_hdr_tready), 64'h1);
`ifdef TURF_UDP_FRAMER_LENCHECK_EN
      chk("reset len_err", 64'(len_err), 64'h0);
      chk("reset len_err_count", 64'(len_err_count), 64'h0);
`endif
      aresetn = 1'b1;
      @(posedge aclk); #1;

      for (int i = 0; i < vq.size(); i++) apply(vq[i], $sformatf("v%0d", i));

      // Reset mid-payload: src 0A0B, dst 0C0D, len 32 -> 40, reset after beat1
      apply(mk(1'b1,16'd32,16'h0A0B,16'h0C0D, 1'b1,P0,8'hFF,1'b0,1'b0, 1'b1, 1'b0,Z64,8'h00,1'b0,1'b0, 1'b1,1'b0), "rst accept");
      apply(mk(1'b0,16'h0,16'h0,16'h0C0D, 1'b1,P0,8'hFF,1'b0,1'b0, 1'b1, 1'b1,64'h0000_2800_0D0C_0B0A,8'hFF,1'b0,1'b0, 1'b0,1'b0), "rst hdr");
      apply(mk(1'b0,16'h0,16'h0,16'h0C0D, 1'b1,P0,8'hFF,1'b0,1'b0, 1'b1, 1'b1,P0,8'hFF,1'b0,1'b0, 1'b0,1'b1), "rst beat0");
      apply(mk(1'b0,16'h0,16'h0,16'h0C0D, 1'b1,P1,8'hFF,1'b0,1'b0, 1'b1, 1'b1,P1,8'hFF,1'b0,1'b0, 1'b0,1'b1), "rst beat1");
      bus.s_payload_tvalid = 1'b1; bus.s_payload_tdata = P2; bus.m_udp_tready = 1'b1;
      aresetn = 1'b0;
      #1;
      chk("midrst m_tvalid", 64'(bus.m_udp_tvalid), 64'h0);
      chk("midrst hdr_tready", 64'(bus.s_hdr_tready), 64'h1);
      chk("midrst pl_tready", 64'(bus.s_payload_tready), 64'h0);
      @(negedge aclk);
      idle_inputs();
      aresetn = 1'b1;
      @(posedge aclk); #1;
      // Fresh fragment after reset: src 2222, dst 3333, len 8 -> 16
      apply(mk(1'b1,16'd8,16'h2222,16'h3333, 1'b0,Z64,8'h00,1'b0,1'b0, 1'b1, 1'b0,Z64,8'h00,1'b0,1'b0, 1'b1,1'b0), "post accept");
      apply(mk(1'b0,16'h0,16'h0,16'h3333, 1'b1,P3,8'hFF,1'b1,1'b0, 1'b1, 1'b1,64'h0000_1000_3333_2222,8'hFF,1'b0,1'b0, 1'b0,1'b0), "post hdr");
      apply(mk(1'b0,16'h0,16'h0,16'h3333, 1'b1,P3,8'hFF,1'b1,1'b0, 1'b1, 1'b1,P3,8'hFF,1'b1,1'b0, 1'b0,1'b1), "post beat");
      apply(mk(1'b0,16'h0,16'h0,16'h3333, 1'b0,Z64,8'h00,1'b0,1'b0, 1'b1, 1'b0,Z64,8'h00,1'b0,1'b0, 1'b1,1'b0), "post idle");

`ifdef TURF_UDP_FRAMER_LENCHECK_EN
      chk("lc count before", 64'(len_err_count), 64'h0);
      // Header says 20 bytes, payload carries 24: len 20 -> 28
      apply(mk(1'b1,16'd20,16'h0001,16'h0002, 1'b0,Z64,8'h00,1'b0,1'b0, 1'b1, 1'b0,Z64,8'h00,1'b0,1'b0, 1'b1,1'b0), "lc1 accept");
      apply(mk(1'b0,16'h0,16'h0,16'h0002, 1'b0,Z64,8'h00,1'b0,1'b0, 1'b1, 1'b1,64'h0000_1C00_0200_0100,8'hFF,1'b0,1'b0, 1'b0,1'b0), "lc1 hdr");
      apply(mk(1'b0,16'h0,16'h0,16'h0002, 1'b1,P0,8'hFF,1'b0,1'b0, 1'b1, 1'b1,P0,8'hFF,1'b0,1'b0, 1'b0,1'b1), "lc1 b0");
      apply(mk(1'b0,16'h0,16'h0,16'h0002, 1'b1,P1,8'hFF,1'b0,1'b0, 1'b1, 1'b1,P1,8'hFF,1'b0,1'b0, 1'b0,1'b1), "lc1 b1");
      chk("lc1 no early pulse", 64'(len_err), 64'h0);
      apply(mk(1'b0,16'h0,16'h0,16'h0002, 1'b1,P2,8'hFF,1'b1,1'b0, 1'b1, 1'b1,P2,8'hFF,1'b1,1'b0, 1'b0,1'b1), "lc1 b2");
      chk("lc1 len_err pulse", 64'(len_err), 64'h1);
      chk("lc1 count", 64'(len_err_count), 64'h1);
      apply(mk(1'b0,16'h0,16'h0,16'h0002, 1'b0,Z64,8'h00,1'b0,1'b0, 1'b1, 1'b0,Z64,8'h00,1'b0,1'b0, 1'b1,1'b0), "lc1 idle");
      chk("lc1 pulse ends", 64'(len_err), 64'h0);
      // Correct 8/8/4 payload for a 20-byte header
      apply(mk(1'b1,16'd20,16'h0001,16'h0002, 1'b0,Z64,8'h00,1'b0,1'b0, 1'b1, 1'b0,Z64,8'h00,1'b0,1'b0, 1'b1,1'b0), "lc2 accept");
      apply(mk(1'b0,16'h0,16'h0,16'h0002, 1'b0,Z64,8'h00,1'b0,1'b0, 1'b1, 1'b1,64'h0000_1C00_0200_0100,8'hFF,1'b0,1'b0, 1'b0,1'b0), "lc2 hdr");
      apply(mk(1'b0,16'h0,16'h0,16'h0002, 1'b1,P0,8'hFF,1'b0,1'b0, 1'b1, 1'b1,P0,8'hFF,1'b0,1'b0, 1'b0,1'b1), "lc2 b0");
      apply(mk(1'b0,16'h0,16'h0,16'h0002, 1'b1,P1,8'hFF,1'b0,1'b0, 1'b1, 1'b1,P1,8'hFF,1'b0,1'b0, 1'b0,1'b1), "lc2 b1");
      apply(mk(1'b0,16'h0,16'h0,16'h0002, 1'b1,P2,8'h0F,1'b1,1'b0, 1'b1, 1'b1,P2,8'h0F,1'b1,1'b0, 1'b0,1'b1), "lc2 b2");
      chk("lc2 no pulse", 64'(len_err), 64'h0);
      apply(mk(1'b0,16'h0,16'h0,16'h0002, 1'b0,Z64,8'h00,1'b0,1'b0, 1'b1, 1'b0,Z64,8'h00,1'b0,1'b0, 1'b1,1'b0), "lc2 idle");
      chk("lc2 count held", 64'(len_err_count), 64'h1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
